// File: rtl/result_capture_module_pkg.sv
// result_capture_module_pkg: register map, response code and AXI-Lite FSM states
package result_capture_module_pkg;
  localparam logic [7:0] RESULT_BASE = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h40;
  localparam logic [7:0] ARGMAX_OFS = 8'h44;
  localparam logic [7:0] CONTROL_OFS = 8'h48;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/result_capture_module_if.sv
// result_capture_module_if: AXI4-Lite bus bundle with master/slave views
interface result_capture_module_if;
  logic [31:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [31:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/result_capture_module_axi_lite_slave_if.sv
// axi_lite_slave_if: AXI4-Lite handshake FSMs exposing a simple register-port strobe interface
module axi_lite_slave_if
  import result_capture_module_pkg::*;
(
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  result_capture_module_if.slave s,
  output logic wr_en,
  output logic [7:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0] wr_strb,
  output logic rd_en,
  output logic [7:0] rd_addr,
  input  logic [31:0] rd_data
);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic unused_bits;
  assign unused_bits = ^{s.awaddr[31:8], s.awprot, s.araddr[31:8], s.arprot};
  assign wr_addr = s.awaddr[7:0];
  assign wr_data = s.wdata;
  assign wr_strb = s.wstrb;
  assign rd_addr = s.araddr[7:0];
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      s.rdata <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (rd_en) s.rdata <= rd_data;
    end
  // ready strobes are gated by reset so they read low while reset is held
  always_comb begin
    wr_en = s_axi_aresetn && w_state == W_IDLE && s.awvalid && s.wvalid;
    rd_en = s_axi_aresetn && r_state == R_IDLE && s.arvalid;
    w_next = wr_en ? W_RESP : (w_state == W_RESP && s.bready) ? W_IDLE : w_state;
    r_next = rd_en ? R_DATA : (r_state == R_DATA && s.rready) ? R_IDLE : r_state;
    s.awready = wr_en;
    s.wready = wr_en;
    s.arready = rd_en;
    s.bvalid = w_state == W_RESP;
    s.rvalid = r_state == R_DATA;
    s.bresp = RESP_OKAY;
    s.rresp = RESP_OKAY;
  end
endmodule

// File: rtl/result_capture_module.sv
// result_capture_module: captures DEPTH stream words, tracks signed argmax, exposes them over AXI-Lite
module result_capture_module
  import result_capture_module_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int DATA_W = 32
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic [DATA_W-1:0] y_tdata,
  input  logic y_tvalid,
  output logic y_tready,
  output logic done,
  result_capture_module_if.slave s_axi
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] buf_q [2**IW];
  logic [4:0] count, next_count;
  logic [IW-1:0] argmax, widx;
  logic signed [DATA_W-1:0] max_q;
  logic wr_en, rd_en, clr, beat, update, unused_bits;
  logic [7:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0] wr_strb;
  logic [5:0] sel;
  axi_lite_slave_if u_axi (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .s(s_axi),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  assign unused_bits = ^{wr_data[31:1], wr_strb[3:1], wr_addr[1:0], rd_addr[1:0], rd_en};
  assign y_tready = !done;
  // a clear in the same cycle as a beat restarts the capture with that beat at index 0
  always_comb begin
    beat = y_tvalid && y_tready;
    clr = wr_en && wr_addr[7:2] == CONTROL_OFS[7:2] && wr_strb[0] && wr_data[0];
    widx = clr ? '0 : count[IW-1:0];
    next_count = (clr ? 5'd0 : count) + {4'd0, beat};
    update = clr || count == 5'd0 || $signed(y_tdata) > max_q;
    sel = rd_addr[7:2] - RESULT_BASE[7:2];
    rd_data = rd_addr[7:2] == STATUS_OFS[7:2] ? {done, 26'd0, count} :
              rd_addr[7:2] == ARGMAX_OFS[7:2] ? 32'(argmax) :
              sel < 6'(DEPTH) ? 32'(buf_q[sel[IW-1:0]]) : '0;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      count <= '0;
      done <= 1'b0;
      argmax <= '0;
      max_q <= '0;
    end else if (clr || beat) begin
      count <= next_count;
      done <= next_count == 5'(DEPTH);
      if (beat && update) begin
        max_q <= y_tdata;
        argmax <= widx;
      end else if (clr) begin
        max_q <= '0;
        argmax <= '0;
      end
    end
  always_ff @(posedge s_axi_aclk)
    if (beat) buf_q[widx] <= y_tdata;
endmodule

// File: tb/tb_result_capture_module.sv
// tb_result_capture_module: directed self-checking bench for result_capture_module
module tb_result_capture_module;
  logic s_axi_aclk = 1'b0;
  logic s_axi_aresetn = 1'b0;
  logic [31:0] y_tdata = '0;
  logic y_tvalid = 1'b0;
  logic y_tready, done;
  logic [31:0] rd;
  int vectors = 0;
  int miscompares = 0;
  int sq[$];
  int b4[5] = '{7, 100, 3, 3, 3};
  result_capture_module_if axi();
  result_capture_module #(.DEPTH(10), .DATA_W(32)) dut (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .y_tdata(y_tdata),
    .y_tvalid(y_tvalid),
    .y_tready(y_tready),
    .done(done),
    .s_axi(axi)
  );
  always #5 s_axi_aclk = ~s_axi_aclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    axi.araddr = a;
    axi.arvalid = 1'b1;
    axi.rready = 1'b1;
    #1;
    while (!axi.arready && n < 20) begin
      @(negedge s_axi_aclk);
      #1;
      n++;
    end
    chk("ar_timeout", 32'(n < 20), 1);
    @(negedge s_axi_aclk);
    axi.arvalid = 1'b0;
    chk("rvalid", 32'(axi.rvalid), 1);
    chk("rresp", 32'(axi.rresp), 0);
    d = axi.rdata;
    @(negedge s_axi_aclk);
    axi.rready = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, exp);
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    axi.awaddr = a;
    axi.wdata = d;
    axi.wstrb = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    #1;
    while (!(axi.awready && axi.wready) && n < 20) begin
      @(negedge s_axi_aclk);
      #1;
      n++;
    end
    chk("aw_timeout", 32'(n < 20), 1);
    @(negedge s_axi_aclk);
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    chk("bvalid", 32'(axi.bvalid), 1);
    chk("bresp", 32'(axi.bresp), 0);
    @(negedge s_axi_aclk);
    axi.bready = 1'b0;
  endtask
  task automatic stream();
    foreach (sq[i]) begin
      y_tdata = sq[i];
      y_tvalid = 1'b1;
      chk("y_tready_beat", 32'(y_tready), 1);
      @(negedge s_axi_aclk);
    end
    y_tvalid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end
  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    repeat (30) @(negedge s_axi_aclk);
    chk("rst_tready", 32'(y_tready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_awready", 32'(axi.awready), 0);
    chk("rst_arready", 32'(axi.arready), 0);
    chk("rst_bvalid", 32'(axi.bvalid), 0);
    chk("rst_rvalid", 32'(axi.rvalid), 0);
    chk("rst_rdata", axi.rdata, 0);
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    rd_chk("status_rst", 32'h40, 0);
    rd_chk("argmax_rst", 32'h44, 0);
    sq = '{5, -3, 9, 2, 9, 0, -7, 1, 8, 4};
    stream();
    chk("done_full", 32'(done), 1);
    chk("tready_full", 32'(y_tready), 0);
    y_tdata = 32'hDEAD;
    y_tvalid = 1'b1;
    repeat (3) @(negedge s_axi_aclk);
    chk("tready_hold", 32'(y_tready), 0);
    y_tvalid = 1'b0;
    rd_chk("status_full", 32'h40, 32'h8000000A);
    rd_chk("argmax_tie", 32'h44, 2);
    rd_chk("result6", 32'h18, 32'hFFFFFFF9);
    rd_chk("result9_nodead", 32'h24, 4);
    rd_chk("result0", 32'h00, 5);
    rd_chk("unmapped_4c", 32'h4C, 0);
    rd_chk("result_oob", 32'h3C, 0);
    rd_chk("control_rd", 32'h48, 0);
    axi_write(32'h48, 1);
    chk("done_clr", 32'(done), 0);
    chk("tready_clr", 32'(y_tready), 1);
    sq = '{-10, -20, -5};
    stream();
    rd_chk("status_3", 32'h40, 3);
    chk("done_3", 32'(done), 0);
    rd_chk("argmax_neg", 32'h44, 2);
    rd_chk("result0_new", 32'h00, 32'hFFFFFFF6);
    rd_chk("result3_stale", 32'h0C, 2);
    rd_chk("result8_stale", 32'h20, 8);
    for (int i = 0; i < 5; i++) begin
      y_tdata = b4[i];
      y_tvalid = 1'b1;
      if (i == 0) begin
        axi.araddr = 32'h40;
        axi.arvalid = 1'b1;
        axi.rready = 1'b0;
        #1;
        chk("arready_snap", 32'(axi.arready), 1);
      end else begin
        axi.arvalid = 1'b0;
        chk("rvalid_hold", 32'(axi.rvalid), 1);
        chk("rdata_hold", axi.rdata, 3);
      end
      @(negedge s_axi_aclk);
    end
    y_tvalid = 1'b0;
    chk("rdata_hold_end", axi.rdata, 3);
    axi.rready = 1'b1;
    @(negedge s_axi_aclk);
    axi.rready = 1'b0;
    chk("rvalid_done", 32'(axi.rvalid), 0);
    rd_chk("status_8", 32'h40, 8);
    rd_chk("argmax_4", 32'h44, 4);
    rd_chk("result4", 32'h10, 100);
    axi_write(32'h40, 0);
    axi_write(32'h44, 7);
    rd_chk("status_ro", 32'h40, 8);
    rd_chk("argmax_ro", 32'h44, 4);
    axi.awaddr = 32'h48;
    axi.wdata = 1;
    axi.wstrb = 4'hF;
    axi.bready = 1'b0;
    axi.awvalid = 1'b1;
    repeat (4) begin
      #1;
      chk("awready_lone", 32'(axi.awready), 0);
      chk("wready_lone", 32'(axi.wready), 0);
      @(negedge s_axi_aclk);
    end
    axi.wvalid = 1'b1;
    #1;
    chk("awready_pair", 32'(axi.awready), 1);
    chk("wready_pair", 32'(axi.wready), 1);
    @(negedge s_axi_aclk);
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
    chk("bvalid_late", 32'(axi.bvalid), 1);
    @(negedge s_axi_aclk);
    chk("bvalid_held", 32'(axi.bvalid), 1);
    axi.bready = 1'b1;
    @(negedge s_axi_aclk);
    axi.bready = 1'b0;
    chk("bvalid_drop", 32'(axi.bvalid), 0);
    rd_chk("status_clr2", 32'h40, 0);
    rd_chk("argmax_clr2", 32'h44, 0);
    sq = '{1, 2, 3, 4};
    stream();
    axi.araddr = 32'h40;
    axi.arvalid = 1'b1;
    axi.rready = 1'b0;
    #1;
    chk("arready_pre_rst", 32'(axi.arready), 1);
    @(negedge s_axi_aclk);
    chk("rdata_pre_rst", axi.rdata, 4);
    #2 s_axi_aresetn = 1'b0;
    #1;
    chk("arst_rvalid", 32'(axi.rvalid), 0);
    chk("arst_rdata", axi.rdata, 0);
    chk("arst_arready", 32'(axi.arready), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_tready", 32'(y_tready), 1);
    axi.arvalid = 1'b0;
    repeat (2) @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    rd_chk("status_post_rst", 32'h40, 0);
    sq = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    stream();
    chk("done_restream", 32'(done), 1);
    rd_chk("status_restream", 32'h40, 32'h8000000A);
    rd_chk("argmax_restream", 32'h44, 5);
    rd_chk("result5_restream", 32'h14, 9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
